// File: rtl/mips_tb_pkg.sv
// Shared types and constants for the MIPS store-traffic write checker.
package mips_tb_pkg;

  typedef enum logic [1:0] {
    CHK_IDLE,
    CHK_RUN,
    CHK_PASS,
    CHK_FAIL
  } chk_state_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_ADDR    = 2'd1;
  localparam logic [1:0] FC_DATA    = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

  localparam logic [31:0] IGNORE_ADDR_DEF = 32'd80;

endpackage

// File: rtl/mem_write_checker_if.sv
// Table-programming, store-bus and verdict signals of the write checker.
// master drives the table and the core's store bus; slave is the checker.
interface mem_write_checker_if #(
  parameter int NUM_EXP = 8
);
  localparam int IW = $clog2(NUM_EXP);

  logic          exp_we;
  logic [IW-1:0] exp_idx;
  logic [31:0]   exp_addr;
  logic [31:0]   exp_data;
  logic [IW:0]   exp_count;
  logic          start;
  logic          memwrite;
  logic [31:0]   dataadr;
  logic [31:0]   writedata;
  logic          busy;
  logic          pass;
  logic          fail;
  logic [1:0]    fail_code;
  logic [IW-1:0] fail_idx;
  logic [31:0]   fail_addr;
  logic [31:0]   fail_data;
  logic [15:0]   cycles;

  modport master (
    output exp_we, exp_idx, exp_addr, exp_data, exp_count, start,
           memwrite, dataadr, writedata,
    input  busy, pass, fail, fail_code, fail_idx, fail_addr, fail_data, cycles
  );

  modport slave (
    input  exp_we, exp_idx, exp_addr, exp_data, exp_count, start,
           memwrite, dataadr, writedata,
    output busy, pass, fail, fail_code, fail_idx, fail_addr, fail_data, cycles
  );

endinterface

// File: rtl/exp_table.sv
// Expected-store table: one {addr, data} entry per slot, synchronous write,
// asynchronous read so the current entry is compared in the same cycle as the store.
module exp_table #(
  parameter int NUM_EXP = 8,
  parameter int IW      = $clog2(NUM_EXP)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic [63:0]   wr_dat,
  input  logic [IW-1:0] rd_idx,
  output logic [63:0]   rd_dat
);

  logic [63:0] mem [NUM_EXP];

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_dat;
  end

  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/mem_write_checker.sv
// In-order checker of the core's store bus against a programmed table of
// expected (addr, data) pairs; verdict registered on the deciding store's edge.
module mem_write_checker
  import mips_tb_pkg::*;
#(
  parameter int          NUM_EXP     = 8,
  parameter logic [31:0] IGNORE_ADDR = IGNORE_ADDR_DEF,
  parameter int          TIMEOUT     = 4096
) (
  input logic                clk,
  input logic                reset,
  mem_write_checker_if.slave chk
);

  localparam int          IW      = $clog2(NUM_EXP);
  localparam logic [IW:0] CNT_MAX = (IW+1)'(NUM_EXP);
  localparam logic [15:0] CYC_MAX = 16'(TIMEOUT - 1);

  chk_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   cnt_q, cnt_d;
  logic [15:0]   cycles_q, cycles_d;
  logic [1:0]    code_q, code_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   faddr_q, faddr_d;
  logic [31:0]   fdata_q, fdata_d;
  logic [63:0]   entry;
  logic [31:0]   entry_addr, entry_data;
  logic          store;

  exp_table #(.NUM_EXP(NUM_EXP), .IW(IW)) u_table (
    .clk    (clk),
    .we     (chk.exp_we),
    .wr_idx (chk.exp_idx),
    .wr_dat ({chk.exp_addr, chk.exp_data}),
    .rd_idx (ptr_q),
    .rd_dat (entry)
  );

  assign {entry_addr, entry_data} = entry;
  assign store = chk.memwrite && (chk.dataadr != IGNORE_ADDR);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    code_d   = code_q;
    idx_d    = idx_q;
    faddr_d  = faddr_q;
    fdata_d  = fdata_q;
    if (chk.start) begin
      ptr_d    = '0;
      cycles_d = '0;
      code_d   = FC_NONE;
      idx_d    = '0;
      faddr_d  = '0;
      fdata_d  = '0;
      cnt_d    = (chk.exp_count > CNT_MAX) ? CNT_MAX : chk.exp_count;
      state_d  = (chk.exp_count == '0) ? CHK_PASS : CHK_RUN;
    end else if (state_q == CHK_RUN) begin
      if (cycles_q != CYC_MAX) cycles_d = cycles_q + 16'd1;
      // A checked store in the last cycle outranks the timeout.
      if (store) begin
        if (chk.dataadr != entry_addr) begin
          state_d = CHK_FAIL;
          code_d  = FC_ADDR;
        end else if (chk.writedata != entry_data) begin
          state_d = CHK_FAIL;
          code_d  = FC_DATA;
        end else begin
          ptr_d = ptr_q + 1'b1;
          if (({1'b0, ptr_q} + 1'b1) == cnt_q) state_d = CHK_PASS;
        end
      end else if (cycles_q == CYC_MAX) begin
        state_d = CHK_FAIL;
        code_d  = FC_TIMEOUT;
      end
      if (state_d == CHK_FAIL) begin
        idx_d   = ptr_q;
        faddr_d = chk.dataadr;
        fdata_d = chk.writedata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= CHK_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      cycles_q <= '0;
      code_q   <= FC_NONE;
      idx_q    <= '0;
      faddr_q  <= '0;
      fdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      faddr_q  <= faddr_d;
      fdata_q  <= fdata_d;
    end
  end

  assign chk.busy      = (state_q == CHK_RUN);
  assign chk.pass      = (state_q == CHK_PASS);
  assign chk.fail      = (state_q == CHK_FAIL);
  assign chk.fail_code = code_q;
  assign chk.fail_idx  = idx_q;
  assign chk.fail_addr = faddr_q;
  assign chk.fail_data = fdata_q;
  assign chk.cycles    = cycles_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed store scenarios plus randomized runs,
// compared every cycle against a transaction-level model of the checker.
module tb_mem_write_checker;
  localparam int NUM_EXP = 8;
  localparam int IW      = 3;
  localparam int TIMEOUT = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_write_checker_if #(.NUM_EXP(NUM_EXP)) chk ();

  mem_write_checker #(
    .NUM_EXP     (NUM_EXP),
    .IGNORE_ADDR (32'd80),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .chk   (chk)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_state = M_IDLE;
  int          m_ptr = 0, m_cnt = 0, m_run_edges = 0;
  int          m_code = 0, m_idx = 0;
  logic [31:0] m_faddr = '0, m_fdata = '0;
  logic [31:0] m_taddr [NUM_EXP];
  logic [31:0] m_tdata [NUM_EXP];
  bit          m_seen;

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task m_fail(input int code);
    m_state = M_FAIL;
    m_code  = code;
    m_idx   = m_ptr;
    m_faddr = chk.dataadr;
    m_fdata = chk.writedata;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = M_IDLE; m_ptr = 0; m_cnt = 0; m_run_edges = 0;
      m_code = 0; m_idx = 0; m_faddr = '0; m_fdata = '0;
    end else begin
      if (chk.start) begin
        m_cnt = (int'(chk.exp_count) > NUM_EXP) ? NUM_EXP : int'(chk.exp_count);
        m_ptr = 0; m_run_edges = 0;
        m_code = 0; m_idx = 0; m_faddr = '0; m_fdata = '0;
        m_state = (m_cnt == 0) ? M_PASS : M_RUN;
      end else if (m_state == M_RUN) begin
        m_run_edges++;
        m_seen = chk.memwrite && (chk.dataadr != 32'd80);
        if (m_seen) begin
          if (chk.dataadr != m_taddr[m_ptr])        m_fail(1);
          else if (chk.writedata != m_tdata[m_ptr]) m_fail(2);
          else begin
            m_ptr++;
            if (m_ptr == m_cnt) m_state = M_PASS;
          end
        end else if (m_run_edges >= TIMEOUT) begin
          m_fail(3);
        end
      end
      if (chk.exp_we) begin
        m_taddr[chk.exp_idx] = chk.exp_addr;
        m_tdata[chk.exp_idx] = chk.exp_data;
      end
    end
  end

  always @(negedge clk) begin
    chk_val("busy",      chk.busy,      m_state == M_RUN);
    chk_val("pass",      chk.pass,      m_state == M_PASS);
    chk_val("fail",      chk.fail,      m_state == M_FAIL);
    chk_val("fail_code", chk.fail_code, m_code);
    chk_val("fail_idx",  chk.fail_idx,  m_idx);
    chk_val("fail_addr", chk.fail_addr, m_faddr);
    chk_val("fail_data", chk.fail_data, m_fdata);
    chk_val("cycles",    chk.cycles,    (m_run_edges > TIMEOUT-1) ? TIMEOUT-1 : m_run_edges);
  end

  task tick;
    @(posedge clk);
    #2;
    chk.start    = 1'b0;
    chk.exp_we   = 1'b0;
    chk.memwrite = 1'b0;
  endtask

  task prog(input int idx, input logic [31:0] a, input logic [31:0] d);
    chk.exp_we = 1'b1; chk.exp_idx = IW'(idx); chk.exp_addr = a; chk.exp_data = d;
    tick();
  endtask

  task do_start(input int n);
    chk.exp_count = (IW+1)'(n); chk.start = 1'b1;
    tick();
  endtask

  task store(input logic [31:0] a, input logic [31:0] d);
    chk.memwrite = 1'b1; chk.dataadr = a; chk.writedata = d;
    tick();
  endtask

  task nop;
    tick();
  endtask

  task check_all_zero(input string tag);
    chk_val({tag, "_busy"},   chk.busy, 0);
    chk_val({tag, "_pass"},   chk.pass, 0);
    chk_val({tag, "_fail"},   chk.fail, 0);
    chk_val({tag, "_code"},   chk.fail_code, 0);
    chk_val({tag, "_idx"},    chk.fail_idx, 0);
    chk_val({tag, "_addr"},   chk.fail_addr, 0);
    chk_val({tag, "_data"},   chk.fail_data, 0);
    chk_val({tag, "_cycles"}, chk.cycles, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run not finished, limit 2000000 ns");
    $fatal(1, "watchdog expired");
  end

  int sel, k, n;

  initial begin
    chk.exp_we = 0; chk.exp_idx = '0; chk.exp_addr = '0; chk.exp_data = '0;
    chk.exp_count = '0; chk.start = 0; chk.memwrite = 0;
    chk.dataadr = '0; chk.writedata = '0;
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < NUM_EXP; i++) prog(i, 32'h100 + 32'(i * 4), $urandom);

    // addi/addi/add/sw program: store of 1000 to address 20 on the fourth cycle
    prog(0, 32'd20, 32'd1000);
    do_start(1);
    nop(); nop(); nop();
    chk_val("prog_busy_before_sw", chk.busy, 1);
    store(32'd20, 32'd1000);
    chk_val("prog_pass", chk.pass, 1);
    chk_val("prog_fail", chk.fail, 0);
    chk_val("prog_cycles", chk.cycles, 4);
    chk_val("model_prog_pass", m_state, M_PASS);

    // Same program storing a wrong value
    do_start(1);
    nop(); nop(); nop();
    store(32'd20, 32'd999);
    chk_val("data_fail", chk.fail, 1);
    chk_val("data_code", chk.fail_code, 2);
    chk_val("data_idx", chk.fail_idx, 0);
    chk_val("data_addr", chk.fail_addr, 20);
    chk_val("data_data", chk.fail_data, 999);
    chk_val("model_data_code", m_code, 2);

    // Ignored address does not consume an entry
    prog(1, 32'd24, 32'd7);
    do_start(2);
    store(32'd80, 32'd5);
    chk_val("ign_busy", chk.busy, 1);
    store(32'd20, 32'd1000);
    chk_val("ign_pass_early", chk.pass, 0);
    store(32'd24, 32'd7);
    chk_val("ign_pass", chk.pass, 1);
    chk_val("ign_cycles", chk.cycles, 3);

    // Address mismatch on the second store
    do_start(2);
    store(32'd20, 32'd1000);
    store(32'd28, 32'd7);
    chk_val("addr_code", chk.fail_code, 1);
    chk_val("addr_idx", chk.fail_idx, 1);
    chk_val("addr_addr", chk.fail_addr, 28);
    chk_val("model_addr_idx", m_idx, 1);

    // Timeout with no stores; bus values are captured
    chk.dataadr = 32'h1234; chk.writedata = 32'h5678;
    do_start(2);
    repeat (15) nop();
    chk_val("to_busy_15", chk.busy, 1);
    chk_val("to_cycles_15", chk.cycles, 15);
    nop();
    chk_val("to_fail", chk.fail, 1);
    chk_val("to_code", chk.fail_code, 3);
    chk_val("to_cycles", chk.cycles, 15);
    chk_val("to_addr", chk.fail_addr, 32'h1234);
    chk_val("to_data", chk.fail_data, 32'h5678);
    chk_val("model_to_code", m_code, 3);

    // Reset mid-run, then an empty-table start passes immediately
    do_start(2);
    nop(); nop();
    rst_n = 1'b0;
    #3;
    check_all_zero("midrst");
    tick();
    check_all_zero("midrst_hold");
    rst_n = 1'b1;
    nop();
    do_start(0);
    chk_val("empty_pass", chk.pass, 1);
    chk_val("empty_busy", chk.busy, 0);
    chk_val("empty_cycles", chk.cycles, 0);

    // Randomized runs
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < NUM_EXP; i++)
        if ($urandom_range(0, 1) == 1) prog(i, $urandom & 32'hFC, $urandom);
      n = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 8);
      do_start(n);
      for (int c = 0; c < 22; c++) begin
        sel = $urandom_range(0, 99);
        k = m_ptr % NUM_EXP;
        if (sel < 55)      store(m_taddr[k], m_tdata[k]);
        else if (sel < 63) store(32'd80, $urandom);
        else if (sel < 67) store(m_taddr[k] + 32'd4, m_tdata[k]);
        else if (sel < 71) store(m_taddr[k], m_tdata[k] ^ 32'h1);
        else if (sel < 74) do_start($urandom_range(0, 9));
        else if (sel < 78) prog($urandom_range(0, NUM_EXP-1), $urandom & 32'hFC, $urandom);
        else if (sel < 80) begin
          rst_n = 1'b0;
          tick();
          rst_n = 1'b1;
        end else begin
          chk.dataadr = $urandom; chk.writedata = $urandom;
          nop();
        end
      end
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
